// File: rtl/snn_pkg.sv
// Shared sizes, FSM state encoding and the skid payload type for the SNN
// hidden-layer input sequencer.
package snn_pkg;

    localparam int unsigned NUM_PIXELS  = 784;
    localparam int unsigned NUM_NEURONS = 32;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WADDR_W     = 15;
    localparam int unsigned NIDX_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        NEXT,
        DONE
    } seq_state_t;

    // One pixel sample travelling towards the MAC: its bit and weight address.
    typedef struct packed {
        logic               pix_bit;
        logic [WADDR_W-1:0] waddr;
    } mac_sample_t;

endpackage

// File: rtl/seq_skid_reg.sv
// One-entry skid buffer holding the pixel sample that was in flight when
// downstream backpressure arrived.
module seq_skid_reg
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        pop,
    input  mac_sample_t din,
    output logic        valid,
    output mac_sample_t dout
);

    // Capture on load, release on pop; load wins if both are seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/snn_input_sequencer.sv
// Sequences the hidden-layer pass: scans the loader RAM once per neuron,
// feeds pixel bits with matching weight-ROM addresses to the MAC, and
// issues clear / neuron_done / done strobes.
// Optional build macro SEQ_ZERO_SKIP_EN: accumulate only pixels whose bit is 1.
module snn_input_sequencer
    import snn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready,
    input  logic               q,
    input  logic               stall,
    output logic [ADDR_W-1:0]  addr,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               mac_en,
    output logic               mac_bit,
    output logic               acc_clr,
    output logic [NIDX_W-1:0]  neuron_idx,
    output logic               neuron_done,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0]  LAST_PIX    = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [NIDX_W-1:0]  LAST_NEURON = NIDX_W'(NUM_NEURONS - 1);
    localparam logic [WADDR_W-1:0] PIX_STRIDE  = WADDR_W'(NUM_PIXELS);

    seq_state_t         state;
    logic               ready_q;
    logic               drain_cnt;
    logic [WADDR_W-1:0] base;

    // Stage 1: address issued last cycle, q now valid for it.
    logic               s1_v;
    logic [WADDR_W-1:0] s1_waddr;
    mac_sample_t        s1_sample;

    logic               stall_act;
    logic               issue;
    logic               skid_load;
    logic               skid_pop;
    logic               skid_valid;
    mac_sample_t        skid_dout;
    logic               emit;
    mac_sample_t        emit_sample;

    assign stall_act   = stall && ((state == SCAN) || (state == DRAIN));
    assign issue       = (state == SCAN) && !stall_act;
    assign s1_sample   = '{pix_bit: q, waddr: s1_waddr};
    assign skid_load   = stall_act && s1_v;
    assign skid_pop    = !stall_act && skid_valid;
    assign emit        = !stall_act && (skid_valid || s1_v);
    assign emit_sample = skid_valid ? skid_dout : s1_sample;

    seq_skid_reg u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .pop   (skid_pop),
        .din   (s1_sample),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    // Control FSM: pixel counter (addr), neuron index, weight base and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            addr        <= '0;
            drain_cnt   <= 1'b0;
            base        <= '0;
            neuron_idx  <= '0;
            acc_clr     <= 1'b0;
            neuron_done <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ready_q     <= ready;
            acc_clr     <= 1'b0;
            neuron_done <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready && !ready_q) begin
                        state   <= CLEAR;
                        acc_clr <= 1'b1;
                        busy    <= 1'b1;
                        addr    <= '0;
                    end
                end
                CLEAR: begin
                    state <= SCAN;
                end
                SCAN: begin
                    if (!stall) begin
                        if (addr == LAST_PIX) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt) begin
                            state       <= NEXT;
                            neuron_done <= 1'b1;
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    addr <= '0;
                    if (neuron_idx == LAST_NEURON) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        neuron_idx <= '0;
                        base       <= '0;
                    end else begin
                        state      <= CLEAR;
                        acc_clr    <= 1'b1;
                        neuron_idx <= neuron_idx + NIDX_W'(1);
                        base       <= base + PIX_STRIDE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sample pipeline: weight address follows the read address, then the
    // sample (from skid first, else stage 1) is presented to the MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v        <= 1'b0;
            s1_waddr    <= '0;
            mac_en      <= 1'b0;
            mac_bit     <= 1'b0;
            weight_addr <= '0;
        end else begin
            s1_v <= issue;
            if (issue) begin
                s1_waddr <= base + WADDR_W'(addr);
            end
`ifdef SEQ_ZERO_SKIP_EN
            mac_en <= emit && emit_sample.pix_bit;
            if (emit && emit_sample.pix_bit) begin
                mac_bit <= 1'b1;
            end
`else
            mac_en <= emit;
            if (emit) begin
                mac_bit <= emit_sample.pix_bit;
            end
`endif
            if (emit) begin
                weight_addr <= emit_sample.waddr;
            end
        end
    end

endmodule
